// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring shift-subtract step per cycle.
// Define MULDIV_SIGNED_EN to honour sgn; otherwise every operation is unsigned.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CW-1:0]    r_cnt;
  logic             r_op;
  logic             r_neg_a;
  logic             r_neg_b;
  logic             r_bzero;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_res_lo;
  logic [WIDTH-1:0] r_res_hi;
  logic             r_dbz;
  logic             r_done;

  logic             w_sgn_en;
`ifdef MULDIV_SIGNED_EN
  assign w_sgn_en = sgn;
`else
  logic w_unused_sgn;
  assign w_unused_sgn = sgn;
  assign w_sgn_en     = 1'b0;
`endif

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  assign w_a_neg = w_sgn_en & a[WIDTH-1];
  assign w_b_neg = w_sgn_en & b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -a : a;
  assign w_b_mag = w_b_neg ? -b : b;

  // Multiply step: conditionally add multiplicand into the high half, shift product right.
  logic [WIDTH:0] w_sum;
  assign w_sum = {1'b0, r_hi} + ({1'b0, r_opb} & {(WIDTH+1){r_lo[0]}});

  // Divide step: shift the next dividend bit into the partial remainder and try the subtract.
  logic [WIDTH:0]   w_shift_rem;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;
  assign w_shift_rem = {r_hi, r_lo[WIDTH-1]};
  assign w_ge        = w_shift_rem >= {1'b0, r_opb};
  assign w_sub       = w_shift_rem[WIDTH-1:0] - r_opb;

  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  assign w_prod_fix = (r_neg_a ^ r_neg_b) ? -{r_hi, r_lo} : {r_hi, r_lo};
  assign w_quo_fix  = (r_neg_a ^ r_neg_b) ? -r_lo : r_lo;
  assign w_rem_fix  = r_neg_a ? -r_hi : r_hi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (r_cnt == CW'(WIDTH-1)) w_state_next = S_FIX;
      S_FIX:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_op     <= 1'b0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_bzero  <= 1'b0;
      r_opb    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_res_lo <= '0;
      r_res_hi <= '0;
      r_dbz    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_cnt   <= '0;
          r_op    <= op;
          r_neg_a <= w_a_neg;
          r_neg_b <= w_b_neg;
          r_bzero <= (b == '0);
          r_hi    <= '0;
          r_lo    <= op ? w_a_mag : w_b_mag;
          r_opb   <= op ? w_b_mag : w_a_mag;
        end
        S_RUN: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_op) begin
            r_hi <= w_ge ? w_sub : w_shift_rem[WIDTH-1:0];
            r_lo <= {r_lo[WIDTH-2:0], w_ge};
          end else begin
            {r_hi, r_lo} <= {w_sum, r_lo[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          r_done <= 1'b1;
          if (!r_op) begin
            {r_res_hi, r_res_lo} <= w_prod_fix;
            r_dbz <= 1'b0;
          end else if (r_bzero) begin
            // Zero divisor: the partial remainder ends up holding |a|; restore a's sign.
            r_res_lo <= '1;
            r_res_hi <= w_rem_fix;
            r_dbz    <= 1'b1;
          end else begin
            r_res_lo <= w_quo_fix;
            r_res_hi <= w_rem_fix;
            r_dbz    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign done        = r_done;
  assign result_lo   = r_res_lo;
  assign result_hi   = r_res_hi;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (WIDTH=32): expected results queued at issue, checked on done.
`timescale 1ns/1ps
module tb_muldiv_unit;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         op;
  logic         sgn;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result_lo;
  logic [W-1:0] result_hi;
  logic         div_by_zero;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .sgn(sgn), .a(a), .b(b),
    .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dbz;
    int           cyc;
    string        tag;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic void model(input logic iop, input logic isg, input logic [W-1:0] ia,
                                input logic [W-1:0] ib, output logic [W-1:0] lo,
                                output logic [W-1:0] hi, output logic dbz);
    logic        s;
    longint      sa, sb, p, qq, rr;
    logic [63:0] up;
`ifdef MULDIV_SIGNED_EN
    s = isg;
`else
    s = 1'b0 & isg;
`endif
    sa  = longint'($signed(ia));
    sb  = longint'($signed(ib));
    dbz = 1'b0;
    if (!iop) begin
      if (s) begin p = sa * sb; {hi, lo} = p; end
      else begin up = {32'b0, ia} * {32'b0, ib}; {hi, lo} = up; end
    end else if (ib == '0) begin
      lo = '1; hi = ia; dbz = 1'b1;
    end else if (s) begin
      qq = sa / sb; rr = sa % sb;
      lo = qq[W-1:0]; hi = rr[W-1:0];
    end else begin
      lo = ia / ib; hi = ia % ib;
    end
  endfunction

  // Called at a falling edge while the unit is idle (or in its done cycle).
  task automatic issue(input logic iop, input logic isg, input logic [W-1:0] ia,
                       input logic [W-1:0] ib, input logic [W-1:0] elo,
                       input logic [W-1:0] ehi, input logic edbz, input string tag);
    exp_t e;
    op = iop; sgn = isg; a = ia; b = ib; start = 1'b1;
    e.lo = elo; e.hi = ehi; e.dbz = edbz; e.cyc = cyc + 1 + LAT; e.tag = tag;
    q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom; b = $urandom; op = ~iop; sgn = ~isg;
    chk({tag, "_busy"}, 64'(busy), 64'(1));
  endtask

  task automatic issue_m(input logic iop, input logic isg, input logic [W-1:0] ia,
                         input logic [W-1:0] ib, input string tag);
    logic [W-1:0] lo, hi;
    logic         dbz;
    model(iop, isg, ia, ib, lo, hi, dbz);
    issue(iop, isg, ia, ib, lo, hi, dbz, tag);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, 64'(q.size()), 64'(0));
    q.delete();
    @(negedge clk);
    chk({tag, "_idle"}, 64'(busy), 64'(0));
  endtask

  always @(negedge clk) begin
    if (!reset && done) begin
      if (q.size() == 0) begin
        chk("spurious_done", 64'(done), 64'(0));
      end else begin
        mon_e = q.pop_front();
        chk({mon_e.tag, "_lo"},  64'(result_lo),   64'(mon_e.lo));
        chk({mon_e.tag, "_hi"},  64'(result_hi),   64'(mon_e.hi));
        chk({mon_e.tag, "_dbz"}, 64'(div_by_zero), 64'(mon_e.dbz));
        chk({mon_e.tag, "_lat"}, 64'(cyc),         64'(mon_e.cyc));
        $display("txn %s lo=%h hi=%h dbz=%0d", mon_e.tag, result_lo, result_hi, div_by_zero);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; op = 1'b0; sgn = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_lo",   64'(result_lo), 64'(0));
    chk("rst_hi",   64'(result_hi), 64'(0));
    chk("rst_dbz",  64'(div_by_zero), 64'(0));

    // first start accepted on the edge right after reset release
    reset = 1'b0;
    issue(1'b0, 1'b0, 32'd7, 32'd6, 32'd42, 32'd0, 1'b0, "mul_7x6");
    wait_idle("mul_7x6");
`ifdef MULDIV_SIGNED_EN
    issue(1'b0, 1'b1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 32'hFFFFFFFF, 1'b0, "smul_m3x5");
    wait_idle("smul");
    issue(1'b0, 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFD, 32'h15, 32'h0, 1'b0, "smul_m7xm3");
    wait_idle("smul2");
`else
    issue(1'b0, 1'b1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 32'h4, 1'b0, "smul_m3x5");
    wait_idle("smul");
    issue(1'b0, 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFD, 32'h15, 32'hFFFFFFF6, 1'b0, "smul_m7xm3");
    wait_idle("smul2");
`endif
    issue(1'b1, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, "div_100_7");
    wait_idle("div");
`ifdef MULDIV_SIGNED_EN
    issue(1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, "sdiv_m7_2");
    wait_idle("sdiv");
    issue(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b0, "sdiv_min_m1");
    wait_idle("sdiv_min");
`else
    issue(1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'h1, 1'b0, "sdiv_m7_2");
    wait_idle("sdiv");
    issue(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, "sdiv_min_m1");
    wait_idle("sdiv_min");
`endif
    issue(1'b1, 1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, "div_5_0");
    wait_idle("dbz");
    issue(1'b0, 1'b0, 32'd9, 32'd1, 32'd9, 32'd0, 1'b0, "mul_9x1");
    wait_idle("dbz_clear");
    issue(1'b1, 1'b1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, "sdiv_m5_0");
    wait_idle("sdbz");

    // start held high throughout busy: exactly one completion
    issue_m(1'b1, 1'b0, 32'd1000, 32'd33, "hold_start");
    start = 1'b1;
    repeat (20) @(negedge clk);
    start = 1'b0;
    wait_idle("hold_start");
    repeat (3) @(negedge clk);

    // back-to-back: second start issued in the done cycle
    @(negedge clk);
    issue_m(1'b0, 1'b0, 32'h12345678, 32'h9ABCDEF0, "b2b_first");
    n = 0;
    while (!done && n < 60) begin @(negedge clk); n++; end
    chk("b2b_done_seen", 64'(done), 64'(1));
    issue_m(1'b1, 1'b0, 32'hDEADBEEF, 32'd12345, "b2b_second");
    wait_idle("b2b");

    // reset 10 edges into a multiply aborts it
    issue(1'b0, 1'b0, 32'd3, 32'd4, 32'd12, 32'd0, 1'b0, "abort");
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    q.delete();
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_lo",   64'(result_lo), 64'(0));
    chk("abort_hi",   64'(result_hi), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_lo_hold", 64'(result_lo), 64'(0));
    chk("abort_busy2",   64'(busy), 64'(0));

    for (int i = 0; i < 12; i++) begin
      logic         rop, rsg;
      logic [W-1:0] ra, rb;
      rop = 1'($urandom_range(0, 1));
      rsg = 1'($urandom_range(0, 1));
      ra  = $urandom;
      case (i % 4)
        0: rb = '0;
        1: rb = $urandom_range(1, 1000);
        2: rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      issue_m(rop, rsg, ra, rb, $sformatf("rnd%0d", i));
      wait_idle("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use an asynchronous, active-high reset.
REQ-002 The block SHALL have parameter WIDTH, default 32, which sets the operand width (legal values: even, 8..64).
REQ-003 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin an operation.
REQ-006 The block SHALL have port op, input, 1 bit: 0 = multiply, 1 = divide.
REQ-007 The block SHALL have port sgn, input, 1 bit: 1 = two's-complement operands, 0 = unsigned operands.
REQ-008 The block SHALL have port a, input, WIDTH bits: multiplicand or dividend.
REQ-009 The block SHALL have port b, input, WIDTH bits: multiplier or divisor.
REQ-010 The block SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-012 The block SHALL have port result_lo, output, WIDTH bits: the low half of the product, or the quotient.
REQ-013 The block SHALL have port result_hi, output, WIDTH bits: the high half of the product, or the remainder.
REQ-014 The block SHALL have port div_by_zero, output, 1 bit: the last completed divide had b == 0.

Function
REQ-015 The block SHALL implement a three-state FSM with states IDLE, RUN and FIX.
- IDLE -> RUN on a rising edge with start=1.
- RUN -> FIX after WIDTH iterations.
- FIX -> IDLE after one cycle.
REQ-016 On accepting start, the block SHALL latch a, b, op and sgn; input changes after that edge SHALL have no effect on the operation.
REQ-017 Multiply SHALL be a shift-add of one bit per RUN cycle on operand magnitudes, producing a 2*WIDTH-bit result split into result_hi:result_lo.
REQ-018 Divide SHALL be a restoring shift-subtract of one quotient bit per RUN cycle on operand magnitudes.
REQ-019 The FIX state SHALL apply sign correction when sgn=1:
- product negated when the operand signs differ;
- quotient negated when the operand signs differ;
- remainder takes the sign of the dividend.
REQ-020 busy SHALL be 1 in RUN and FIX and 0 in IDLE.
REQ-021 done SHALL rise exactly WIDTH+1 rising edges after the accepting edge and SHALL be high for exactly one cycle.
REQ-022 result_lo, result_hi and div_by_zero SHALL update only on the edge that raises done, and SHALL then hold until the next completion.
REQ-023 start asserted while busy=1 SHALL be ignored (not queued).
REQ-024 start asserted in the cycle where done=1 SHALL be accepted, giving back-to-back operations with no bubble.
REQ-025 Divide with b == 0 SHALL keep the normal latency and SHALL return:
- quotient = all ones;
- remainder = a;
- div_by_zero = 1.
REQ-026 A signed divide of the most-negative value by -1 SHALL return quotient = the most-negative value and remainder = 0, with div_by_zero = 0.
REQ-027 div_by_zero SHALL be 0 after any completed multiply or non-zero divide.

Reset
REQ-028 While reset=1, the FSM SHALL be in IDLE and busy, done, result_lo, result_hi and div_by_zero SHALL all be 0.
REQ-029 Reset asserted mid-operation SHALL abort the operation immediately, with no done pulse and no result update.
REQ-030 After reset deasserts, the first start SHALL be accepted on the next rising edge.

Configuration
REQ-031 With macro MULDIV_SIGNED_EN defined, the block SHALL honour sgn as specified above.
REQ-032 Without MULDIV_SIGNED_EN, the block SHALL ignore sgn and treat all operations as unsigned.
REQ-033 Without MULDIV_SIGNED_EN, the FIX state SHALL still occupy one cycle so that latency is unchanged.
REQ-034 Without MULDIV_SIGNED_EN, REQ-026 SHALL not apply.

Verification (WIDTH=32)
REQ-035 Multiply, unsigned: a=7, b=6, op=0, sgn=0 -> done exactly 33 edges later; result_lo=42, result_hi=0, div_by_zero=0.
REQ-036 Multiply, signed: a=0xFFFFFFFD, b=5, sgn=1 -> result_hi:result_lo = 0xFFFFFFFF:0xFFFFFFF1. Without MULDIV_SIGNED_EN -> 0x00000004:0xFFFFFFF1.
REQ-037 Divide: 100/7 unsigned -> quotient 14, remainder 2.
REQ-038 Divide, signed: -7/2 with sgn=1 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
REQ-039 Divide by zero: 5/0 -> quotient 0xFFFFFFFF, remainder 5, div_by_zero=1. A following 9*1 -> div_by_zero=0.
REQ-040 Control:
- reset pulsed 10 edges into a multiply -> busy=0, no done pulse, results 0;
- start held high during busy -> exactly one done per accepted operation;
- start in the done cycle -> second done exactly 33 edges later.
